// File: rtl/tuner_phy_pkg.sv
// -----------------------------------------------------------------------------
// tuner_phy_pkg
// Shared types for the tuner PHY control blocks.
//   tuner_sweep_state_e : sweep controller FSM states
//   tuner_sweep_cfg_t   : sweep configuration latched when a sweep is accepted
// The config struct is sized by TUNER_DAC_W / TUNER_SETTLE_W; the sweep
// controller's DAC_WIDTH / SETTLE_W parameters default to these values.
// -----------------------------------------------------------------------------
package tuner_phy_pkg;

   localparam int unsigned TUNER_DAC_W    = 8;
   localparam int unsigned TUNER_ADC_W    = 8;
   localparam int unsigned TUNER_SETTLE_W = 8;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StIssue  = 2'd1,
      StSettle = 2'd2,
      StDone   = 2'd3
   } tuner_sweep_state_e;

   typedef struct packed {
      logic [TUNER_DAC_W-1:0]    code_start;
      logic [TUNER_DAC_W-1:0]    code_end;
      logic [TUNER_DAC_W-1:0]    code_step;
      logic [TUNER_SETTLE_W-1:0] settle;
   } tuner_sweep_cfg_t;

endpackage

// File: rtl/tuner_sweep_search_ctrl_if.sv
// -----------------------------------------------------------------------------
// tuner_sweep_search_ctrl_if
// Tune/measure transaction port between the sweep controller (master) and
// the search-channel transaction adapter (slave).
//   txn_val        : master -> slave, transaction request
//   txn_tune_code  : master -> slave, code for the current transaction
//   txn_rdy        : slave -> master, response ready (fire = val & rdy)
//   txn_meas_power : slave -> master, measured power, valid on fire
// -----------------------------------------------------------------------------
interface tuner_sweep_search_ctrl_if #(
   parameter int unsigned DAC_WIDTH = 8,
   parameter int unsigned ADC_WIDTH = 8
);

   logic                 txn_val;
   logic [DAC_WIDTH-1:0] txn_tune_code;
   logic                 txn_rdy;
   logic [ADC_WIDTH-1:0] txn_meas_power;

   modport master (
      output txn_val,
      output txn_tune_code,
      input  txn_rdy,
      input  txn_meas_power
   );

   modport slave (
      input  txn_val,
      input  txn_tune_code,
      output txn_rdy,
      output txn_meas_power
   );

endinterface

// File: rtl/tuner_settle_timer.sv
// -----------------------------------------------------------------------------
// tuner_settle_timer
// Load / count-down / expire timer for the post-transaction settle window.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : load i_load_val (takes priority over counting)
//   i_load_val     : settle cycle count
//   i_en           : decrement while enabled (stops at zero)
//   o_expire       : count is 1, i.e. this is the last settle cycle
// -----------------------------------------------------------------------------
module tuner_settle_timer #(
   parameter int unsigned SETTLE_W = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_load,
   input  logic [SETTLE_W-1:0] i_load_val,
   input  logic                i_en,
   output logic                o_expire
);

   logic [SETTLE_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = i_load_val;
      end else if (i_en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_expire = (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/tuner_sweep_search_ctrl.sv
// -----------------------------------------------------------------------------
// tuner_sweep_search_ctrl
// Steps the ring tune code from start to end by step, issuing one
// tune/measure transaction per point, waiting a settle window between
// points, and tracking the code with the highest measured power.
//   i_clk, i_rst_n    : clock, async active-low reset
//   i_start / i_abort : start pulse (ignored while busy) / sticky abort request
//   i_code_*          : start, end, step codes, latched at start
//   i_settle_cycles   : idle cycles after each transaction, latched at start
//   txn               : transaction port (master)
//   o_busy / o_done   : sweep in progress / one-cycle completion pulse
//   o_aborted / o_err : completion qualifiers, held until next start
//   o_peak_code/power : best point of the last sweep
//   o_num_points      : transactions completed in the last sweep
// -----------------------------------------------------------------------------
module tuner_sweep_search_ctrl
   import tuner_phy_pkg::*;
#(
   parameter int unsigned DAC_WIDTH = TUNER_DAC_W,
   parameter int unsigned ADC_WIDTH = TUNER_ADC_W,
   parameter int unsigned SETTLE_W  = TUNER_SETTLE_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic                   i_abort,
   input  logic [DAC_WIDTH-1:0]   i_code_start,
   input  logic [DAC_WIDTH-1:0]   i_code_end,
   input  logic [DAC_WIDTH-1:0]   i_code_step,
   input  logic [SETTLE_W-1:0]    i_settle_cycles,
   tuner_sweep_search_ctrl_if.master txn,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_aborted,
   output logic                   o_err,
   output logic [DAC_WIDTH-1:0]   o_peak_code,
   output logic [ADC_WIDTH-1:0]   o_peak_power,
   output logic [DAC_WIDTH:0]     o_num_points
);

   tuner_sweep_state_e   state_q, state_d;
   tuner_sweep_cfg_t     cfg_q, cfg_d;
   logic [DAC_WIDTH-1:0] cur_code_q, cur_code_d;
   logic [DAC_WIDTH-1:0] peak_code_q, peak_code_d;
   logic [ADC_WIDTH-1:0] peak_power_q, peak_power_d;
   logic [DAC_WIDTH:0]   num_points_q, num_points_d;
   logic                 abort_q, abort_d;
   logic                 err_q, err_d;

   logic                 busy;
   logic                 fire;
   logic                 abort_eff;
   logic [DAC_WIDTH:0]   next_code;
   logic                 timer_load;
   logic                 timer_expire;

   assign busy      = (state_q == StIssue) || (state_q == StSettle);
   assign fire      = txn.txn_val && txn.txn_rdy;
   // Abort raised this cycle counts immediately, so a SETTLE abort ends next cycle.
   assign abort_eff = abort_q || (busy && i_abort);
   // One extra bit so a step past the top of the code range never wraps.
   assign next_code = {1'b0, cur_code_q} + {1'b0, cfg_q.code_step};

   always_comb begin
      state_d      = state_q;
      cfg_d        = cfg_q;
      cur_code_d   = cur_code_q;
      peak_code_d  = peak_code_q;
      peak_power_d = peak_power_q;
      num_points_d = num_points_q;
      abort_d      = abort_q;
      err_d        = err_q;
      timer_load   = 1'b0;

      if (busy && i_abort) begin
         abort_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               cfg_d.code_start = i_code_start;
               cfg_d.code_end   = i_code_end;
               cfg_d.code_step  = i_code_step;
               cfg_d.settle     = i_settle_cycles;
               peak_power_d     = '0;
               peak_code_d      = i_code_start;
               num_points_d     = '0;
               abort_d          = 1'b0;
               err_d            = 1'b0;
               cur_code_d       = i_code_start;
               if ((i_code_step == '0) || (i_code_start > i_code_end)) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            if (fire) begin
               num_points_d = num_points_q + 1'b1;
               // Strict compare: the lowest code wins ties.
               if (txn.txn_meas_power > peak_power_q) begin
                  peak_power_d = txn.txn_meas_power;
                  peak_code_d  = cur_code_q;
               end
               if ((next_code > {1'b0, cfg_q.code_end}) || abort_eff) begin
                  state_d = StDone;
               end else begin
                  cur_code_d = next_code[DAC_WIDTH-1:0];
                  if (cfg_q.settle != '0) begin
                     timer_load = 1'b1;
                     state_d    = StSettle;
                  end
               end
            end
         end
         StSettle: begin
            if (abort_eff) begin
               state_d = StDone;
            end else if (timer_expire) begin
               state_d = StIssue;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= StIdle;
         cfg_q        <= '0;
         cur_code_q   <= '0;
         peak_code_q  <= '0;
         peak_power_q <= '0;
         num_points_q <= '0;
         abort_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         cur_code_q   <= cur_code_d;
         peak_code_q  <= peak_code_d;
         peak_power_q <= peak_power_d;
         num_points_q <= num_points_d;
         abort_q      <= abort_d;
         err_q        <= err_d;
      end
   end

   tuner_settle_timer #(
      .SETTLE_W (SETTLE_W)
   ) u_settle_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (timer_load),
      .i_load_val (cfg_q.settle),
      .i_en       (state_q == StSettle),
      .o_expire   (timer_expire)
   );

   // Decoded straight from state so an async reset drops val immediately.
   assign txn.txn_val       = (state_q == StIssue);
   assign txn.txn_tune_code = cur_code_q;
   assign o_busy            = busy;
   assign o_done            = (state_q == StDone);
   assign o_aborted         = abort_q;
   assign o_err             = err_q;
   assign o_peak_code       = peak_code_q;
   assign o_peak_power      = peak_power_q;
   assign o_num_points      = num_points_q;

endmodule

// File: tb/tb_tuner_sweep_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tuner_sweep_search_ctrl
// Directed bench for the sweep controller. A 3-cycle-latency adapter model
// answers each transaction from a fixed power table; issued codes, settle
// gaps, completion timing and final results are compared with hand-derived
// values.
// -----------------------------------------------------------------------------
module tb_tuner_sweep_search_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 8;
   localparam int unsigned SW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [DW-1:0] code_start;
   logic [DW-1:0] code_end;
   logic [DW-1:0] code_step;
   logic [SW-1:0] settle_cycles;
   logic          busy;
   logic          done;
   logic          aborted;
   logic          err;
   logic [DW-1:0] peak_code;
   logic [AW-1:0] peak_power;
   logic [DW:0]   num_points;

   always #5 clk = ~clk;

   tuner_sweep_search_ctrl_if #(
      .DAC_WIDTH (DW),
      .ADC_WIDTH (AW)
   ) txn_if ();

   tuner_sweep_search_ctrl #(
      .DAC_WIDTH (DW),
      .ADC_WIDTH (AW),
      .SETTLE_W  (SW)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_start         (start),
      .i_abort         (abort),
      .i_code_start    (code_start),
      .i_code_end      (code_end),
      .i_code_step     (code_step),
      .i_settle_cycles (settle_cycles),
      .txn             (txn_if.master),
      .o_busy          (busy),
      .o_done          (done),
      .o_aborted       (aborted),
      .o_err           (err),
      .o_peak_code     (peak_code),
      .o_peak_power    (peak_power),
      .o_num_points    (num_points)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int pwr [8] = '{5, 9, 9, 3, 7, 1, 1, 1};
   int codes [$];
   int gaps [$];

   int r_dones, r_done_at, r_stab;
   int r_busy_at_done, r_val_at_done, r_aborted, r_err;
   int r_peak_code, r_peak_power, r_npts;
   int r_done_after, r_busy_after, r_npts_after;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Drive one sweep from the start pulse to one cycle after o_done, acting
   // as the adapter. abort_pt selects the point whose transaction (or the
   // settle window after it, when abort_in_settle) gets a one-cycle abort.
   task automatic run_sweep(input logic [DW-1:0] s, input logic [DW-1:0] e,
                            input logic [DW-1:0] st, input logic [SW-1:0] stl,
                            input int abort_pt, input bit abort_in_settle);
      int            lat   = 0;
      int            nfire = 0;
      int            gap   = 0;
      bit            fired = 1'b0;
      logic [DW-1:0] held  = '0;
      codes.delete();
      gaps.delete();
      r_dones   = 0;
      r_done_at = -1;
      r_stab    = 0;
      code_start    = s;
      code_end      = e;
      code_step     = st;
      settle_cycles = stl;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 200 && r_dones == 0; cyc++) begin
         txn_if.txn_rdy = 1'b0;
         abort          = 1'b0;
         if (done) begin
            r_dones++;
            r_done_at      = cyc;
            r_busy_at_done = int'(busy);
            r_val_at_done  = int'(txn_if.txn_val);
            r_aborted      = int'(aborted);
            r_err          = int'(err);
            r_peak_code    = int'(peak_code);
            r_peak_power   = int'(peak_power);
            r_npts         = int'(num_points);
         end else if (txn_if.txn_val) begin
            if (lat == 0) begin
               codes.push_back(int'(txn_if.txn_tune_code));
               held = txn_if.txn_tune_code;
               if (fired) gaps.push_back(gap);
            end else if (txn_if.txn_tune_code != held) begin
               r_stab++;
            end
            lat++;
            if (!abort_in_settle && abort_pt == nfire + 1 && lat == 1) abort = 1'b1;
            if (lat == 3) begin
               txn_if.txn_rdy        = 1'b1;
               txn_if.txn_meas_power = AW'(pwr[nfire % 8]);
               nfire++;
               lat   = 0;
               fired = 1'b1;
               gap   = 0;
            end
         end else begin
            // val dropped before the response arrived
            if (lat != 0) r_stab++;
            if (busy) gap++;
            if (abort_in_settle && abort_pt == nfire && gap == 2) abort = 1'b1;
         end
         @(negedge clk);
      end
      txn_if.txn_rdy = 1'b0;
      abort          = 1'b0;
      r_done_after   = int'(done);
      r_busy_after   = int'(busy);
      r_npts_after   = int'(num_points);
   endtask

   task automatic check_sweep(input string nm, input int exp_n, input int s, input int st,
                              input int exp_gap, input int exp_ngaps, input int exp_pc,
                              input int exp_pp, input int exp_ab, input int exp_err,
                              input int exp_done_at);
      check_eq({nm, ".done_count"}, r_dones, 1);
      check_eq({nm, ".done_at"}, r_done_at, exp_done_at);
      check_eq({nm, ".busy_at_done"}, r_busy_at_done, 0);
      check_eq({nm, ".val_at_done"}, r_val_at_done, 0);
      check_eq({nm, ".num_codes"}, codes.size(), exp_n);
      for (int i = 0; i < codes.size() && i < exp_n; i++) begin
         check_eq($sformatf("%s.code%0d", nm, i), codes[i], s + i * st);
      end
      check_eq({nm, ".num_gaps"}, gaps.size(), exp_ngaps);
      for (int i = 0; i < gaps.size(); i++) begin
         check_eq($sformatf("%s.gap%0d", nm, i), gaps[i], exp_gap);
      end
      check_eq({nm, ".val_stable"}, r_stab, 0);
      check_eq({nm, ".num_points"}, r_npts, exp_n);
      check_eq({nm, ".peak_code"}, r_peak_code, exp_pc);
      check_eq({nm, ".peak_power"}, r_peak_power, exp_pp);
      check_eq({nm, ".aborted"}, r_aborted, exp_ab);
      check_eq({nm, ".err"}, r_err, exp_err);
      check_eq({nm, ".done_single"}, r_done_after, 0);
      check_eq({nm, ".busy_after"}, r_busy_after, 0);
      check_eq({nm, ".num_points_hold"}, r_npts_after, exp_n);
   endtask

   task automatic check_reset_outputs(input string nm);
      check_eq({nm, ".txn_val"}, int'(txn_if.txn_val), 0);
      check_eq({nm, ".txn_code"}, int'(txn_if.txn_tune_code), 0);
      check_eq({nm, ".busy"}, int'(busy), 0);
      check_eq({nm, ".done"}, int'(done), 0);
      check_eq({nm, ".aborted"}, int'(aborted), 0);
      check_eq({nm, ".err"}, int'(err), 0);
      check_eq({nm, ".peak_code"}, int'(peak_code), 0);
      check_eq({nm, ".peak_power"}, int'(peak_power), 0);
      check_eq({nm, ".num_points"}, int'(num_points), 0);
   endtask

   initial begin
      rst_n                 = 1'b0;
      start                 = 1'b0;
      abort                 = 1'b0;
      code_start            = '0;
      code_end              = '0;
      code_step             = '0;
      settle_cycles         = '0;
      txn_if.txn_rdy        = 1'b0;
      txn_if.txn_meas_power = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");

      // Basic sweep 0..8 step 2, back-to-back points
      run_sweep(8'd0, 8'd8, 8'd2, 8'd0, -1, 1'b0);
      check_sweep("sweep_s0", 5, 0, 2, 0, 4, 2, 9, 0, 0, 15);

      // Same sweep with a 4-cycle settle window
      run_sweep(8'd0, 8'd8, 8'd2, 8'd4, -1, 1'b0);
      check_sweep("sweep_s4", 5, 0, 2, 4, 4, 2, 9, 0, 0, 31);

      // Illegal configs
      run_sweep(8'd3, 8'd9, 8'd0, 8'd0, -1, 1'b0);
      check_sweep("step_zero", 0, 3, 0, 0, 0, 3, 0, 0, 1, 0);
      run_sweep(8'd12, 8'd5, 8'd1, 8'd0, -1, 1'b0);
      check_sweep("start_gt_end", 0, 12, 1, 0, 0, 12, 0, 0, 1, 0);

      // Near the top of the code range: no wrap
      run_sweep(8'd250, 8'd255, 8'd10, 8'd0, -1, 1'b0);
      check_sweep("no_wrap", 1, 250, 10, 0, 0, 250, 5, 0, 0, 3);

      // Abort during the 2nd transaction
      run_sweep(8'd0, 8'd8, 8'd2, 8'd0, 2, 1'b0);
      check_sweep("abort_txn", 2, 0, 2, 0, 1, 2, 9, 1, 0, 6);

      // Abort during the settle window after the 1st point
      run_sweep(8'd0, 8'd8, 8'd2, 8'd4, 1, 1'b1);
      check_sweep("abort_settle", 1, 0, 2, 0, 0, 0, 5, 1, 0, 5);

      // Async reset while val is high
      code_start    = 8'd0;
      code_end      = 8'd8;
      code_step     = 8'd2;
      settle_cycles = 8'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      txn_if.txn_rdy        = 1'b1;
      txn_if.txn_meas_power = 8'd9;
      @(negedge clk);
      txn_if.txn_rdy = 1'b0;
      check_eq("mid_rst.pre_val", int'(txn_if.txn_val), 1);
      check_eq("mid_rst.pre_code", int'(txn_if.txn_tune_code), 2);
      check_eq("mid_rst.pre_num_points", int'(num_points), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_sweep(8'd0, 8'd8, 8'd2, 8'd0, -1, 1'b0);
      check_sweep("after_rst", 5, 0, 2, 0, 4, 2, 9, 0, 0, 15);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tuner_sweep_search_ctrl.md
# tuner_sweep_search_ctrl

Sweep controller for one tuner transaction channel. On a start pulse it steps the ring tune code from a start value to an end value by a fixed step. At each point it issues one tune/measure transaction toward the channel's transaction adapter, waits a programmable settle time, and tracks the code that returned the highest measured power. It sits above the search-channel transaction adapter and is the only master of that channel's transaction port.

## Interface
Parameters:
- DAC_WIDTH, 8, tune code width
- ADC_WIDTH, 8, measured power width
- SETTLE_W, 8, width of settle-cycle count

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  start pulse; ignored while o_busy
- i_abort  in  1  abort request; sampled while o_busy
- i_code_start  in  DAC_WIDTH  first code, latched at start
- i_code_end  in  DAC_WIDTH  last allowed code, latched at start
- i_code_step  in  DAC_WIDTH  increment, latched at start
- i_settle_cycles  in  SETTLE_W  idle cycles after each transaction, latched at start
- o_txn_val  out  1  transaction request
- o_txn_tune_code  out  DAC_WIDTH  code for the current transaction
- i_txn_rdy  in  1  adapter response ready; fire = o_txn_val & i_txn_rdy
- i_txn_meas_power  in  ADC_WIDTH  power, valid on fire
- o_busy  out  1  sweep in progress
- o_done  out  1  one-cycle completion pulse
- o_aborted  out  1  qualifies o_done: sweep ended by abort
- o_err  out  1  qualifies o_done: illegal config, no transactions issued
- o_peak_code  out  DAC_WIDTH  code of maximum power
- o_peak_power  out  ADC_WIDTH  maximum power seen
- o_num_points  out  DAC_WIDTH+1  transactions completed in the last sweep

## Operation
- States: IDLE, ISSUE, SETTLE, DONE.
- IDLE, i_start=1:
  - Latch the config.
  - Clear peak_power to 0, peak_code to the start code, and num_points to 0.
  - Clear the abort flag.
  - If step==0 or start>end: go to DONE with o_err=1.
  - Otherwise: cur_code=start, go to ISSUE.
- ISSUE:
  - o_txn_val=1 and o_txn_tune_code=cur_code, both held stable until fire. val must never drop mid-transaction.
  - On fire: num_points++. If meas_power > peak_power (strict), update peak_power and peak_code, so the lowest code wins ties.
  - next = cur_code + step, computed in DAC_WIDTH+1 bits with no wrap.
  - If next > end or the abort flag is set: go to DONE.
  - Else if settle==0: cur_code=next, stay in ISSUE.
  - Else: cur_code=next, load the settle counter, go to SETTLE.
- SETTLE:
  - o_txn_val=0; the counter decrements each cycle.
  - At 1, go to ISSUE.
  - If the abort flag is set, go to DONE immediately.
- i_abort while busy sets a sticky abort flag. An in-flight transaction always completes first.
- DONE: o_done=1 for one cycle, o_busy=0, then IDLE. o_aborted and o_err hold until the next start.
- Peak/num_points outputs hold their values in IDLE until the next accepted start.
- i_start in the same cycle as DONE is ignored.

## Timing
- Reset values:
  - state=IDLE
  - o_txn_val=0, o_txn_tune_code=0
  - o_busy=0, o_done=0, o_aborted=0, o_err=0
  - o_peak_code=0, o_peak_power=0, o_num_points=0
- Start accepted at edge N: o_busy=1 and o_txn_val=1 from cycle N+1.
- Fire at cycle T:
  - Peak/num_points updated at edge T, visible at T+1.
  - With settle=0, the next val (new code) is asserted at T+1.
  - With settle=S, val=0 for S cycles and is reasserted at T+1+S.
- Last fire at T: o_done pulses at T+1, with final results already visible.
- Config error: o_done at N+1, num_points=0.
- The end code is included when reachable: start=10, end=20, step=5 gives 10, 15, 20.
- Codes near the maximum: start=250, end=255, step=10 gives only 250; no wrap to 4.
- Async reset mid-sweep drops o_txn_val immediately, and all state returns to reset values.

## Structure
- Add to tuner_phy_pkg:
  - tuner_sweep_state_e (IDLE, ISSUE, SETTLE, DONE; 2 bits)
  - a packed struct tuner_sweep_cfg_t {start, end, step, settle} for the latched config.
- One sub-module, tuner_settle_timer: load/count-down/expire, SETTLE_W wide.
- Peak compare and code stepping stay inline.

## Test plan
- Sweep start=0, end=8, step=2, settle=0, adapter model with 3-cycle latency. Powers 5, 9, 9, 3, 7 → codes 0, 2, 4, 6, 8 issued; peak_code=2, peak_power=9, num_points=5, one o_done.
- settle=4 with the same sweep → o_txn_val low for exactly 4 cycles after each fire; count checked.
- step=0, or start=12 with end=5 → o_done at N+1, o_err=1, no val asserted.
- start=250, end=255, step=10 → single transaction at code 250, num_points=1, no wraparound.
- i_abort asserted mid-transaction on the 2nd point → that transaction completes with val held stable, then o_done with o_aborted=1 and num_points=2. Repeat with abort during SETTLE → done on the next cycle.
- Async reset pulled low while val=1 → all outputs at reset values in the same cycle. A new start after reset runs a clean sweep.
